// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard port: receiver states, register
// map, STATUS bit layout and default timing constants.
package ps2_pkg;

    // Receiver frame position
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_t;

    // Register offsets inside the selected region; only one address bit decodes
    localparam int REG_DATA_OFS   = 'h0;
    localparam int REG_STATUS_OFS = 'h4;
    localparam int REG_SEL_BIT    = 2;

    // STATUS word bit positions
    localparam int STAT_NE_BIT     = 0;
    localparam int STAT_FULL_BIT   = 1;
    localparam int STAT_OVF_BIT    = 2;
    localparam int STAT_PERR_BIT   = 3;
    localparam int STAT_COUNT_LSB  = 8;

    // DATA word: empty flag sits just above the byte
    localparam int DATA_EMPTY_BIT  = 8;

    // 100 us of silence at 50 MHz abandons a partial frame
    localparam int TIMEOUT_DEFAULT = 5000;

    // Consecutive equal samples needed to move the filtered clock level
    localparam int FILTER_LEN      = 4;

endpackage

// File: rtl/ps2_kbd_port_if.sv
// CPU-side access strobes for the keyboard port region. The shared data bus
// itself stays a plain inout on the port so it can be resolved with the rest
// of the board's tri-state bus.
interface ps2_kbd_port_if;
    logic        sel;
    logic        Memread;
    logic [27:0] Addrin;

    modport master (output sel, output Memread, output Addrin);
    modport slave  (input  sel, input  Memread, input  Addrin);
endinterface

// File: rtl/ps2_sync_filter.sv
// Two-flop synchroniser plus glitch filter for the PS/2 clock line. The
// filtered level only moves after FILTER_LEN consecutive equal synchronised
// samples; a one-cycle fall pulse marks each filtered high-to-low transition.
module ps2_sync_filter
    import ps2_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic fall
);

    logic                  sync1;
    logic                  sync2;
    logic [FILTER_LEN-2:0] hist;
    logic                  level;
    logic [FILTER_LEN-1:0] samples;

    assign samples = {hist, sync2};

    // Synchronise, keep the recent sample history, and move the level once it is unanimous
    // NOTE: every flop here uses <= so all stages see the previous cycle's values, giving a true shift chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            hist  <= '1;
            level <= 1'b1;
            fall  <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            hist  <= {hist[FILTER_LEN-3:0], sync2};
            fall  <= 1'b0;
            if (level && samples == '0) begin
                level <= 1'b0;
                fall  <= 1'b1;
            end else if (!level && samples == '1) begin
                level <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_kbd_port.sv
// Memory-mapped PS/2 keyboard receiver. Deserialises device frames, queues
// the bytes in a small FIFO and answers CPU reads of DATA (pops on the end of
// the access) and STATUS (clears the sticky flags on the end of the access).
// Build option: define PS2_PARITY_CHECK_EN to drop frames with bad odd parity
// and report them through the sticky perr flag.
module ps2_kbd_port
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = TIMEOUT_DEFAULT
) (
    input  logic          clk_50mhz,
    input  logic          rst,
    input  logic          ps2_clk,
    input  logic          ps2_data,
    ps2_kbd_port_if.slave cpu,
    inout  wire  [31:0]   BUS
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    // ---------------- input conditioning ----------------
    logic fall;
    logic data_s1;
    logic data_s2;

    ps2_sync_filter u_clk_filter (
        .clk  (clk_50mhz),
        .rst  (rst),
        .raw  (ps2_clk),
        .fall (fall)
    );

    // Data line only needs synchronising; it is sampled long after it settles
    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
        end else begin
            data_s1 <= ps2_data;
            data_s2 <= data_s1;
        end
    end

    // ---------------- receiver ----------------
    rx_state_t       state;
    rx_state_t       state_next;
    logic [7:0]      shift;
    logic [2:0]      bit_cnt;
    logic            parity_bit;
    logic [TW-1:0]   timer;
    logic            timeout;
    logic            push_req;
    logic            perr;
`ifdef PS2_PARITY_CHECK_EN
    logic            perr_set;
`endif

    assign timeout = (state != ST_IDLE) && (timer == TW'(TIMEOUT_CYC - 1));

    // Receiver state register
    always_ff @(posedge clk_50mhz) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Frame sequencing on filtered clock falls, with idle timeout back to IDLE
    // NOTE: every output gets a default before the case so no path leaves a signal unassigned (no latches).
    always_comb begin
        state_next = state;
        push_req   = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
        perr_set   = 1'b0;
`endif
        if (fall) begin
            case (state)
                ST_IDLE:   if (!data_s2) state_next = ST_DATA;
                ST_DATA:   if (bit_cnt == 3'd7) state_next = ST_PARITY;
                ST_PARITY: state_next = ST_STOP;
                ST_STOP: begin
                    state_next = ST_IDLE;
`ifdef PS2_PARITY_CHECK_EN
                    if (!(^{shift, parity_bit})) perr_set = 1'b1;
                    else if (data_s2)           push_req = 1'b1;
`else
                    if (data_s2) push_req = 1'b1;
`endif
                end
                default:   state_next = ST_IDLE;
            endcase
        end else if (timeout) begin
            state_next = ST_IDLE;
        end
    end

    // Shift register, bit counter and parity capture
    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            shift      <= '0;
            bit_cnt    <= '0;
            parity_bit <= 1'b0;
        end else if (fall) begin
            case (state)
                ST_IDLE:   bit_cnt <= '0;
                ST_DATA: begin
                    shift   <= {data_s2, shift[7:1]};
                    bit_cnt <= bit_cnt + 3'd1;
                end
                ST_PARITY: parity_bit <= data_s2;
                default:   ;
            endcase
        end
    end

    // Cycles since the last clock fall while a frame is in progress
    always_ff @(posedge clk_50mhz) begin
        if (rst || fall || state == ST_IDLE) timer <= '0;
        else                                 timer <= timer + TW'(1);
    end

    // ---------------- CPU access decode ----------------
    logic rd_data;
    logic rd_stat;
    logic rd_data_q;
    logic rd_stat_q;
    logic pop_req;
    logic stat_done;
    logic bus_en;

    assign bus_en    = cpu.sel & cpu.Memread;
    assign rd_data   = bus_en & ~cpu.Addrin[REG_SEL_BIT];
    assign rd_stat   = bus_en &  cpu.Addrin[REG_SEL_BIT];
    assign pop_req   = rd_data_q & ~rd_data;
    assign stat_done = rd_stat_q & ~rd_stat;

    logic unused_addr;
    assign unused_addr = ^{cpu.Addrin[27:REG_SEL_BIT+1], cpu.Addrin[REG_SEL_BIT-1:0]};

    // Remember the read strobes so the end of each access can be detected
    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            rd_data_q <= 1'b0;
            rd_stat_q <= 1'b0;
        end else begin
            rd_data_q <= rd_data;
            rd_stat_q <= rd_stat;
        end
    end

    // ---------------- FIFO ----------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          empty;
    logic          full;
    logic          do_push;
    logic          do_pop;
    logic          ovf;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(FIFO_DEPTH));
    assign do_pop  = pop_req & ~empty;
    assign do_push = push_req & (~full | do_pop);

    // Byte storage
    // NOTE: storage is deliberately not reset; the reset pointers/count already mark it empty.
    always_ff @(posedge clk_50mhz) begin
        if (do_push) mem[wr_ptr] <= shift;
    end

    // Pointers and occupancy; simultaneous push and pop leave the count alone
    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    // Sticky overflow: a new overflow in the clearing cycle wins
    always_ff @(posedge clk_50mhz) begin
        if (rst)                         ovf <= 1'b0;
        else if (push_req & full & ~do_pop) ovf <= 1'b1;
        else if (stat_done)              ovf <= 1'b0;
    end

`ifdef PS2_PARITY_CHECK_EN
    logic perr_q;
    // Sticky parity error: a new error in the clearing cycle wins
    always_ff @(posedge clk_50mhz) begin
        if (rst)            perr_q <= 1'b0;
        else if (perr_set)  perr_q <= 1'b1;
        else if (stat_done) perr_q <= 1'b0;
    end
    assign perr = perr_q;
`else
    assign perr = 1'b0;
    logic unused_parity;
    assign unused_parity = parity_bit;
`endif

    // ---------------- read data ----------------
    logic [7:0]  head_byte;
    logic [31:0] data_word;
    logic [31:0] status_word;

    assign head_byte = empty ? 8'h00 : mem[rd_ptr];

    // Assemble both register views from registered state
    always_comb begin
        data_word                            = '0;
        data_word[7:0]                       = head_byte;
        data_word[DATA_EMPTY_BIT]            = empty;
        status_word                          = '0;
        status_word[STAT_COUNT_LSB +: 8]     = 8'(count);
        status_word[STAT_PERR_BIT]           = perr;
        status_word[STAT_OVF_BIT]            = ovf;
        status_word[STAT_FULL_BIT]           = full;
        status_word[STAT_NE_BIT]             = ~empty;
    end

    assign BUS = bus_en ? (cpu.Addrin[REG_SEL_BIT] ? status_word : data_word) : 'z;

endmodule
